fp_mul_param: RTL



---
 rtl/fp_mul_param_if.sv | 30 +++
 rtl/fp_mul_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_param_if.sv
// fp_mul_param_if: operand A/B and result Z strobe/ack channels for fp_mul_param.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface fp_mul_param_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic [W-1:0] input_a;
   logic         input_a_stb;
   logic         input_a_ack;
   logic [W-1:0] input_b;
   logic         input_b_stb;
   logic         input_b_ack;
   logic [1:0]   rnd_mode;
   logic [W-1:0] output_z;
   logic         output_z_stb;
   logic         output_z_ack;
   logic [3:0]   flags;

   modport slave (
      input  input_a, input_a_stb, input_b, input_b_stb, rnd_mode, output_z_ack,
      output input_a_ack, input_b_ack, output_z, output_z_stb, flags
   );

   modport master (
      output input_a, input_a_stb, input_b, input_b_stb, rnd_mode, output_z_ack,
      input  input_a_ack, input_b_ack, output_z, output_z_stb, flags
   );
endinterface

// File: rtl/fp_mul_param.sv
// fp_mul_param: parameterised IEEE-754 multiplier, multi-cycle FSM, A/B/Z strobe-ack channels.
// Define FP_MUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_mul_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic          clk,
   input  logic          rst_n,
   fp_mul_param_if.slave bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int M    = MAN_W + 1;
   localparam int EW   = EXP_W + 3;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
   localparam logic signed [EW-1:0] E_INF  = EW'(BIAS + 1);
   localparam logic signed [EW-1:0] E_ZERO = EW'(-BIAS);
   localparam logic signed [EW-1:0] E_MIN  = EW'(1 - BIAS);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic [EXP_W-1:0]     F_BIAS = EXP_W'(BIAS);

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   localparam logic [3:0] GET_A     = 4'd0;
   localparam logic [3:0] GET_B     = 4'd1;
   localparam logic [3:0] UNPACK    = 4'd2;
   localparam logic [3:0] SPECIAL   = 4'd3;
   localparam logic [3:0] NORM_A    = 4'd4;
   localparam logic [3:0] NORM_B    = 4'd5;
   localparam logic [3:0] MUL       = 4'd6;
   localparam logic [3:0] MUL_SPLIT = 4'd7;
   localparam logic [3:0] NORM_1    = 4'd8;
   localparam logic [3:0] NORM_2    = 4'd9;
   localparam logic [3:0] ROUND     = 4'd10;
   localparam logic [3:0] PACK      = 4'd11;
   localparam logic [3:0] PUT_Z     = 4'd12;

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic [3:0]           r_state;
   logic                 r_a_ack, r_b_ack, r_z_stb, r_hold;
   logic [W-1:0]         r_z, r_a, r_b;
   logic [3:0]           r_flags;
   logic [1:0]           r_mode;
   logic [M-1:0]         r_a_m, r_b_m, r_z_m;
   logic signed [EW-1:0] r_a_e, r_b_e, r_z_e;
   logic                 r_a_s, r_b_s, r_z_s;
   logic [2*M-1:0]       r_prod;
   logic                 r_guard, r_round, r_sticky;

   logic                 w_sign;
   logic                 w_a_frac_nz, w_b_frac_nz;
   logic                 w_a_nan, w_b_nan, w_a_snan, w_b_snan;
   logic                 w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic                 w_special;
   logic [W-1:0]         w_spec_z, w_pack_z;
   logic [3:0]           w_spec_flags, w_pack_flags;
   logic                 w_inexact, w_inc, w_ovf, w_to_max, w_flush;
   logic [EXP_W-1:0]     w_e_field;

   assign bus.input_a_ack  = r_a_ack;
   assign bus.input_b_ack  = r_b_ack;
   assign bus.output_z_stb = r_z_stb;
   assign bus.output_z     = r_z;
   assign bus.flags        = r_flags;

   assign w_sign      = r_a_s ^ r_b_s;
   assign w_a_frac_nz = |r_a_m[MAN_W-1:0];
   assign w_b_frac_nz = |r_b_m[MAN_W-1:0];
   assign w_a_nan     = (r_a_e == E_INF) & w_a_frac_nz;
   assign w_b_nan     = (r_b_e == E_INF) & w_b_frac_nz;
   assign w_a_snan    = w_a_nan & !r_a_m[MAN_W-1];
   assign w_b_snan    = w_b_nan & !r_b_m[MAN_W-1];
   assign w_a_inf     = (r_a_e == E_INF) & !w_a_frac_nz;
   assign w_b_inf     = (r_b_e == E_INF) & !w_b_frac_nz;
`ifdef FP_MUL_SUBNORMAL_EN
   assign w_a_zero    = (r_a_e == E_ZERO) & !w_a_frac_nz;
   assign w_b_zero    = (r_b_e == E_ZERO) & !w_b_frac_nz;
   assign w_flush     = 1'b0;
`else
   assign w_a_zero    = (r_a_e == E_ZERO);
   assign w_b_zero    = (r_b_e == E_ZERO);
   assign w_flush     = (r_z_e < E_MIN);
`endif

   always_comb begin
      w_special    = 1'b1;
      w_spec_z     = '0;
      w_spec_flags = 4'b0000;
      if (w_a_nan | w_b_nan) begin
         w_spec_z     = QNAN;
         w_spec_flags = {w_a_snan | w_b_snan, 3'b000};
      end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
         w_spec_z     = QNAN;
         w_spec_flags = 4'b1000;
      end else if (w_a_inf | w_b_inf) begin
         w_spec_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_a_zero | w_b_zero) begin
         w_spec_z = {w_sign, {(W-1){1'b0}}};
      end else begin
         w_special = 1'b0;
      end
   end

   assign w_inexact = r_guard | r_round | r_sticky;

   always_comb begin
      w_inc = 1'b0;
      case (r_mode)
         RM_RNE:  w_inc = r_guard & (r_round | r_sticky | r_z_m[0]);
         RM_RTZ:  w_inc = 1'b0;
         RM_RUP:  w_inc = w_inexact & !r_z_s;
         default: w_inc = w_inexact & r_z_s;
      endcase
   end

   assign w_ovf     = (r_z_e > E_BIAS);
   assign w_to_max  = (r_mode == RM_RTZ) | ((r_mode == RM_RUP) & r_z_s) | ((r_mode == RM_RDN) & !r_z_s);
   assign w_e_field = r_z_e[EXP_W-1:0] + F_BIAS;

   always_comb begin
      w_pack_z     = '0;
      w_pack_flags = 4'b0000;
      if (w_ovf) begin
         w_pack_z     = w_to_max ? {r_z_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                 : {r_z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_pack_flags = 4'b0101;
      end else if (w_flush) begin
         w_pack_z     = {r_z_s, {(W-1){1'b0}}};
         w_pack_flags = 4'b0011;
      end else begin
         // A clear hidden bit only survives to here for subnormal or zero results.
         w_pack_z     = {r_z_s, r_z_m[M-1] ? w_e_field : {EXP_W{1'b0}}, r_z_m[MAN_W-1:0]};
         w_pack_flags = {2'b00, !r_z_m[M-1] & w_inexact, w_inexact};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= GET_A;
         r_a_ack  <= 1'b0;
         r_b_ack  <= 1'b0;
         r_z_stb  <= 1'b0;
         r_z      <= '0;
         r_flags  <= 4'b0000;
         r_hold   <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_mode   <= RM_RNE;
         r_a_m    <= '0;
         r_b_m    <= '0;
         r_z_m    <= '0;
         r_a_e    <= '0;
         r_b_e    <= '0;
         r_z_e    <= '0;
         r_a_s    <= 1'b0;
         r_b_s    <= 1'b0;
         r_z_s    <= 1'b0;
         r_prod   <= '0;
         r_guard  <= 1'b0;
         r_round  <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         case (r_state)
            GET_A: begin
               r_a_ack <= 1'b1;
               if (r_a_ack && bus.input_a_stb) begin
                  r_a     <= bus.input_a;
                  r_a_ack <= 1'b0;
                  r_state <= GET_B;
               end
            end
            GET_B: begin
               r_b_ack <= 1'b1;
               if (r_b_ack && bus.input_b_stb) begin
                  r_b     <= bus.input_b;
                  r_mode  <= bus.rnd_mode;
                  r_b_ack <= 1'b0;
                  r_state <= UNPACK;
               end
            end
            UNPACK: begin
               r_a_m   <= {1'b0, r_a[MAN_W-1:0]};
               r_b_m   <= {1'b0, r_b[MAN_W-1:0]};
               r_a_e   <= $signed({3'b000, r_a[W-2:MAN_W]}) - E_BIAS;
               r_b_e   <= $signed({3'b000, r_b[W-2:MAN_W]}) - E_BIAS;
               r_a_s   <= r_a[W-1];
               r_b_s   <= r_b[W-1];
               r_state <= SPECIAL;
            end
            SPECIAL: begin
               if (w_special) begin
                  // Special results take one registered hold cycle before handoff.
                  if (!r_hold) begin
                     r_hold  <= 1'b1;
                     r_z     <= w_spec_z;
                     r_flags <= w_spec_flags;
                  end else begin
                     r_hold  <= 1'b0;
                     r_state <= PUT_Z;
                  end
               end else begin
                  if (r_a_e == E_ZERO) r_a_e <= E_MIN;
                  else                 r_a_m[M-1] <= 1'b1;
                  if (r_b_e == E_ZERO) r_b_e <= E_MIN;
                  else                 r_b_m[M-1] <= 1'b1;
                  r_state <= NORM_A;
               end
            end
            NORM_A: begin
               if (!r_a_m[M-1]) begin
                  r_a_m <= r_a_m << 1;
                  r_a_e <= r_a_e - E_ONE;
               end else begin
                  r_state <= NORM_B;
               end
            end
            NORM_B: begin
               if (!r_b_m[M-1]) begin
                  r_b_m <= r_b_m << 1;
                  r_b_e <= r_b_e - E_ONE;
               end else begin
                  r_state <= MUL;
               end
            end
            MUL: begin
               r_prod  <= {{M{1'b0}}, r_a_m} * {{M{1'b0}}, r_b_m};
               r_z_e   <= r_a_e + r_b_e + E_ONE;
               r_z_s   <= w_sign;
               r_state <= MUL_SPLIT;
            end
            MUL_SPLIT: begin
               r_z_m    <= r_prod[2*M-1:M];
               r_guard  <= r_prod[M-1];
               r_round  <= r_prod[M-2];
               r_sticky <= |r_prod[M-3:0];
               r_state  <= NORM_1;
            end
            NORM_1: begin
               if (!r_z_m[M-1]) begin
                  r_z_m   <= {r_z_m[M-2:0], r_guard};
                  r_guard <= r_round;
                  r_round <= 1'b0;
                  r_z_e   <= r_z_e - E_ONE;
               end
               r_state <= NORM_2;
            end
            NORM_2: begin
`ifdef FP_MUL_SUBNORMAL_EN
               if (r_z_e < E_MIN) begin
                  r_z_m    <= r_z_m >> 1;
                  r_guard  <= r_z_m[0];
                  r_round  <= r_guard;
                  r_sticky <= r_sticky | r_round;
                  r_z_e    <= r_z_e + E_ONE;
               end else begin
                  r_state <= ROUND;
               end
`else
               // Flush build: no denormalising shifts; underflow is resolved in PACK.
               r_state <= ROUND;
`endif
            end
            ROUND: begin
               if (w_inc) begin
                  if (&r_z_m) begin
                     r_z_m <= {1'b1, {(M-1){1'b0}}};
                     r_z_e <= r_z_e + E_ONE;
                  end else begin
                     r_z_m <= r_z_m + {{(M-1){1'b0}}, 1'b1};
                  end
               end
               r_state <= PACK;
            end
            PACK: begin
               r_z     <= w_pack_z;
               r_flags <= w_pack_flags;
               r_state <= PUT_Z;
            end
            PUT_Z: begin
               r_z_stb <= 1'b1;
               if (r_z_stb && bus.output_z_ack) begin
                  r_z_stb <= 1'b0;
                  r_state <= GET_A;
               end
            end
            default: r_state <= GET_A;
         endcase
      end
   end
endmodule
